// File: rtl/nor_vector_checker.sv
// Drives all four {a,b} combinations into a 2-input gate, samples its output
// after a settle window and reports mismatches against an expected truth table.
module nor_vector_checker #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned LOOPS         = 1,
    parameter logic [3:0]  EXPECT_TT     = 4'b0001
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       c_i,
    output logic       a_o,
    output logic       b_o,
    output logic [1:0] vec_idx,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [7:0] err_count
);

    localparam int unsigned SETTLE_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned LOOP_W   = (LOOPS < 1) ? 1 : $clog2(LOOPS + 1);

    localparam logic [SETTLE_W-1:0] SETTLE_ZERO = SETTLE_W'(0);
    localparam logic [SETTLE_W-1:0] SETTLE_ONE  = SETTLE_W'(1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [LOOP_W-1:0]   LOOP_ZERO   = LOOP_W'(0);
    localparam logic [LOOP_W-1:0]   LOOP_ONE    = LOOP_W'(1);
    localparam logic [LOOP_W-1:0]   LOOP_LAST   = LOOP_W'(LOOPS - 1);

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("nor_vector_checker: SETTLE_CYCLES must be >= 1");
    end
    if (LOOPS < 1) begin : g_bad_loops
        $error("nor_vector_checker: LOOPS must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                state_r;
    logic [1:0]            vec_idx_r;
    logic [SETTLE_W-1:0]   settle_r;
    logic [LOOP_W-1:0]     loop_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  pass_r;
    logic [3:0]            fail_mask_r;
    logic [7:0]            err_count_r;

    logic                  sample_s;
    logic                  mismatch_s;
    logic                  last_vec_s;
    logic                  last_loop_s;

    // Error counter increments but sticks at its maximum value.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        if (value == 8'hFF) begin
            sat_inc8 = 8'hFF;
        end else begin
            sat_inc8 = value + 8'd1;
        end
    endfunction

    function automatic logic [3:0] vec_onehot(input logic [1:0] idx);
        vec_onehot = 4'b0001 << idx;
    endfunction

    // Sample strobe at the last cycle of each settle window plus compare result.
    always_comb begin
        sample_s    = 1'b0;
        mismatch_s  = 1'b0;
        last_vec_s  = (vec_idx_r == 2'd3);
        last_loop_s = (loop_r == LOOP_LAST);
        if ((state_r == ST_RUN) && (settle_r == SETTLE_LAST)) begin
            sample_s   = 1'b1;
            mismatch_s = (c_i != EXPECT_TT[vec_idx_r]);
        end else begin
            sample_s   = 1'b0;
            mismatch_s = 1'b0;
        end
    end

    // Run sequencing, vector stepping and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            vec_idx_r   <= 2'd0;
            settle_r    <= SETTLE_ZERO;
            loop_r      <= LOOP_ZERO;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            fail_mask_r <= 4'b0000;
            err_count_r <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_r     <= ST_RUN;
                        vec_idx_r   <= 2'd0;
                        settle_r    <= SETTLE_ZERO;
                        loop_r      <= LOOP_ZERO;
                        busy_r      <= 1'b1;
                        done_r      <= 1'b0;
                        pass_r      <= 1'b0;
                        fail_mask_r <= 4'b0000;
                        err_count_r <= 8'd0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_RUN: begin
                    if (sample_s) begin
                        settle_r <= SETTLE_ZERO;
                        if (mismatch_s) begin
                            fail_mask_r <= fail_mask_r | vec_onehot(vec_idx_r);
                            err_count_r <= sat_inc8(err_count_r);
                        end else begin
                            err_count_r <= err_count_r;
                        end
                        if (!last_vec_s) begin
                            vec_idx_r <= vec_idx_r + 2'd1;
                        end else if (!last_loop_s) begin
                            vec_idx_r <= 2'd0;
                            loop_r    <= loop_r + LOOP_ONE;
                        end else begin
                            // The final sample's own compare must count toward pass.
                            state_r   <= ST_DONE;
                            vec_idx_r <= 2'd0;
                            loop_r    <= LOOP_ZERO;
                            busy_r    <= 1'b0;
                            done_r    <= 1'b1;
                            pass_r    <= (fail_mask_r == 4'b0000) && !mismatch_s;
                        end
                    end else begin
                        settle_r <= settle_r + SETTLE_ONE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    vec_idx_r <= 2'd0;
                    settle_r  <= SETTLE_ZERO;
                    loop_r    <= LOOP_ZERO;
                    busy_r    <= 1'b0;
                    done_r    <= 1'b0;
                    pass_r    <= 1'b0;
                end
            endcase
        end
    end

    assign a_o       = vec_idx_r[1];
    assign b_o       = vec_idx_r[0];
    assign vec_idx   = vec_idx_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign fail_mask = fail_mask_r;
    assign err_count = err_count_r;

endmodule

// File: tb/tb_nor_vector_checker.sv
// Bench for nor_vector_checker: three parameterisations driven by modelled gates.
module tb_nor_vector_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       pass;
        logic       a;
        logic       b;
        logic [1:0] vec;
        logic [3:0] mask;
        logic [7:0] err;
    } obs_t;

    typedef struct {
        logic [3:0] gate;
        logic [3:0] mask;
        logic [7:0] err;
        logic       pass;
    } vec_t;

    int checks = 0;
    int failures = 0;

    // dut_a: defaults; dut_b: LOOPS=3; dut_c: SETTLE_CYCLES=1, LOOPS=100
    logic [3:0] gate_a = 4'b0001, gate_b = 4'b0001, gate_c = 4'b0001;
    logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic a_a, b_a, busy_a, done_a, pass_a; logic [1:0] vec_a; logic [3:0] mask_a; logic [7:0] err_a;
    logic a_b, b_b, busy_b, done_b, pass_b; logic [1:0] vec_b; logic [3:0] mask_b; logic [7:0] err_b;
    logic a_c, b_c, busy_c, done_c, pass_c; logic [1:0] vec_c; logic [3:0] mask_c; logic [7:0] err_c;
    logic c_a, c_b, c_c;

    // The "gate under test" is any 2-input function given by a truth table.
    assign c_a = gate_a[{a_a, b_a}];
    assign c_b = gate_b[{a_b, b_b}];
    assign c_c = gate_c[{a_c, b_c}];

    nor_vector_checker dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .c_i(c_a), .a_o(a_a), .b_o(b_a),
        .vec_idx(vec_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .fail_mask(mask_a), .err_count(err_a));

    nor_vector_checker #(.SETTLE_CYCLES(4), .LOOPS(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .c_i(c_b), .a_o(a_b), .b_o(b_b),
        .vec_idx(vec_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .fail_mask(mask_b), .err_count(err_b));

    nor_vector_checker #(.SETTLE_CYCLES(1), .LOOPS(100)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .c_i(c_c), .a_o(a_c), .b_o(b_c),
        .vec_idx(vec_c), .busy(busy_c), .done(done_c), .pass(pass_c),
        .fail_mask(mask_c), .err_count(err_c));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic get_obs(input int sel, output obs_t o);
        case (sel)
            0:       o = '{busy_a, done_a, pass_a, a_a, b_a, vec_a, mask_a, err_a};
            1:       o = '{busy_b, done_b, pass_b, a_b, b_b, vec_b, mask_b, err_b};
            default: o = '{busy_c, done_c, pass_c, a_c, b_c, vec_c, mask_c, err_c};
        endcase
    endtask

    task automatic set_start(input int sel, input logic v);
        case (sel)
            0:       start_a = v;
            1:       start_b = v;
            default: start_c = v;
        endcase
    endtask

    task automatic set_gate(input int sel, input logic [3:0] g);
        case (sel)
            0:       gate_a = g;
            1:       gate_b = g;
            default: gate_c = g;
        endcase
    endtask

    // Expected truth table: NOR, built from its definition.
    function automatic logic [3:0] nor_tt();
        logic [3:0] tt;
        for (int i = 0; i < 4; i++) begin
            tt[i] = !(((i >> 1) & 1) != 0 || (i & 1) != 0);
        end
        return tt;
    endfunction

    // Result of a whole run: each wrong truth-table entry misses once per loop.
    task automatic model(input logic [3:0] gate, input int loops,
                         output logic [3:0] m, output logic [7:0] e, output logic p);
        int total;
        m = gate ^ nor_tt();
        total = loops * $countones(m);
        e = (total > 255) ? 8'd255 : 8'(total);
        p = (m == 4'b0000);
    endtask

    // One full run: per-cycle vector/busy checks, optional extra start at cycle poke.
    task automatic run_check(input int sel, input int s, input int l, input logic [3:0] gate,
                             input int poke, input logic [3:0] exp_mask,
                             input logic [7:0] exp_err, input logic exp_pass);
        int n;
        obs_t o;
        logic [1:0] v;
        n = 4 * s * l;
        set_gate(sel, gate);
        @(negedge clk);
        set_start(sel, 1'b1);
        @(negedge clk);
        for (int j = 0; j < n; j++) begin
            get_obs(sel, o);
            v = 2'((j / s) % 4);
            if (j == 0) begin
                chk("cleared_mask", o.mask, 4'b0000);
                chk("cleared_err", o.err, 8'd0);
                chk("cleared_pass", o.pass, 1'b0);
            end
            chk("run_cycle", {o.busy, o.done, o.a, o.b, o.vec}, {1'b1, 1'b0, v[1], v[0], v});
            set_start(sel, (j == poke) ? 1'b1 : 1'b0);
            @(negedge clk);
        end
        set_start(sel, 1'b0);
        get_obs(sel, o);
        chk("end_status", {o.busy, o.done, o.a, o.b, o.vec}, {1'b0, 1'b1, 1'b0, 1'b0, 2'd0});
        chk("end_pass", o.pass, exp_pass);
        chk("end_mask", o.mask, exp_mask);
        chk("end_err", o.err, exp_err);
    endtask

    vec_t tbl[6];

    initial begin
        obs_t o;
        logic [3:0] m;
        logic [7:0] e;
        logic p;
        logic [3:0] g;

        tbl[0] = '{4'b1110, 4'b1111, 8'd4, 1'b0};  // OR (inverted gate)
        tbl[1] = '{4'b0001, 4'b0000, 8'd0, 1'b1};  // correct NOR
        tbl[2] = '{4'b0000, 4'b0001, 8'd1, 1'b0};  // stuck at 0
        tbl[3] = '{4'b1111, 4'b1110, 8'd3, 1'b0};  // stuck at 1
        tbl[4] = '{4'b1000, 4'b1001, 8'd2, 1'b0};  // AND
        tbl[5] = '{4'b0111, 4'b0110, 8'd2, 1'b0};  // NAND

        repeat (2) @(negedge clk);
        get_obs(0, o);
        chk("reset_state", o, '0);
        rst_n = 1'b1;
        @(negedge clk);
        get_obs(0, o);
        chk("idle_state", o, '0);

        for (int i = 0; i < 6; i++) begin
            run_check(0, 4, 1, tbl[i].gate, -1, tbl[i].mask, tbl[i].err, tbl[i].pass);
        end

        // Start during a run is ignored; then start in DONE clears and reruns.
        run_check(0, 4, 1, 4'b1110, 6, 4'b1111, 8'd4, 1'b0);
        run_check(0, 4, 1, 4'b0001, -1, 4'b0000, 8'd0, 1'b1);

        // Asynchronous reset mid-run, between clock edges.
        gate_a = 4'b1110;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 get_obs(0, o);
        chk("async_reset", o, '0);
        @(negedge clk);
        rst_n = 1'b1;
        run_check(0, 4, 1, 4'b0001, -1, 4'b0000, 8'd0, 1'b1);

        run_check(1, 4, 3, 4'b0000, -1, 4'b0001, 8'd3, 1'b0);
        run_check(2, 1, 100, 4'b1110, -1, 4'b1111, 8'd255, 1'b0);

        for (int r = 0; r < 12; r++) begin
            g = 4'($urandom_range(0, 15));
            model(g, 1, m, e, p);
            run_check(0, 4, 1, g, (r % 2 == 0) ? int'($urandom_range(1, 14)) : -1, m, e, p);
        end
        for (int r = 0; r < 4; r++) begin
            g = 4'($urandom_range(0, 15));
            model(g, 3, m, e, p);
            run_check(1, 4, 3, g, -1, m, e, p);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nor_vector_checker.md
Name: nor_vector_checker

Overview:
- Self-checking stimulus/response stage for the 2-input NOR gate block.
- Upstream role: drives the gate's `a`/`b` inputs through all four input combinations.
- Downstream role: samples the gate's `c` output and compares it against an expected truth table.
- Reports per-vector failures, an error count and a pass/done status, so the gate can be exercised on silicon/FPGA without a simulator monitor.

Parameters:
- SETTLE_CYCLES, 4: clock cycles each vector is held before `c_i` is sampled; must be >= 1 (elaboration error otherwise).
- LOOPS, 1: number of full 4-vector sweeps per run; must be >= 1.
- EXPECT_TT, 4'b0001: expected `c` for vector index {a,b}; bit i is the expected output for index i. The default is NOR.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  run request, sampled on rising edge.
- c_i  input  1  output of the gate under test.
- a_o  output  1  gate input a (MSB of vector index).
- b_o  output  1  gate input b (LSB of vector index).
- vec_idx  output  2  index {a_o,b_o} currently driven.
- busy  output  1  run in progress.
- done  output  1  last run complete; held until next accepted start.
- pass  output  1  last run had zero mismatches; valid when done=1.
- fail_mask  output  4  bit i set if vector i mismatched in any loop of the run.
- err_count  output  8  total mismatches in the run, saturating at 255.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (`rst_n`), clock is `clk`.
  - rst_n=0 forces immediately: state=IDLE, a_o=b_o=0, vec_idx=0, busy=0, done=0, pass=0, fail_mask=0, err_count=0, internal counters=0.
  - Reset mid-run aborts the run with no partial result retained.
- States: IDLE, RUN, DONE.
- Start acceptance:
  - start=1 at edge k in IDLE or DONE: state←RUN, busy←1, done←0, pass←0, fail_mask←0, err_count←0, vec_idx←0, a_o/b_o←0/0, settle counter←0, loop counter←0.
  - start while RUN is ignored; no restart and no effect on results.
- Vector timing:
  - Each vector is driven for exactly SETTLE_CYCLES cycles.
  - c_i is sampled at the edge ending the window: edge k+SETTLE_CYCLES×(n+1) for the n-th vector of the run, n = 0..4·LOOPS−1.
- Compare at each sample:
  - Mismatch when c_i != EXPECT_TT[vec_idx].
  - On mismatch: fail_mask[vec_idx]←1; err_count←err_count+1 unless already 255.
- Advance at the same sample edge:
  - vec_idx<3: vec_idx+1, a_o/b_o follow.
  - vec_idx=3 and loop<LOOPS−1: vec_idx←0, loop+1.
  - Otherwise, end of run: state←DONE, busy←0, done←1, a_o/b_o/vec_idx←0, pass←1 iff no mismatch occurred including this final sample.
- Latency: busy is high for exactly 4·SETTLE_CYCLES·LOOPS cycles; done rises at edge k+4·SETTLE_CYCLES·LOOPS.
- In IDLE/DONE, a_o=b_o=0.
- fail_mask and err_count stay valid through DONE until the next accepted start.
- Simultaneous events:
  - start in DONE restarts and clears results at that edge.
  - rst_n low overrides start.
- Counters:
  - settle counter is ceil(log2(SETTLE_CYCLES+1)) bits, minimum 1.
  - loop counter is ceil(log2(LOOPS+1)) bits, minimum 1.
  - No wrap is allowed before the terminal compare.

Test Plan:
- c_i wired to a correct NOR of a_o/b_o, defaults, 1-cycle start pulse → busy 16 cycles; vec_idx 0,1,2,3 each held 4 cycles; done=1, pass=1, fail_mask=0000, err_count=0.
- c_i stuck at 0, LOOPS=3 → done after 48 cycles; pass=0, fail_mask=0001, err_count=3.
- c_i driven by OR of a_o/b_o (inverted gate), defaults → pass=0, fail_mask=1111, err_count=4.
- start pulsed again at cycle 6 of a run → ignored; done still at cycle 16 with unchanged results. Then start in DONE → done drops, results cleared, new 16-cycle run.
- rst_n low at cycle 7 of a run (asynchronous, between edges) → all outputs 0 immediately. After release, a new start produces a normal 16-cycle pass.
- OR-connected c_i, LOOPS=100, SETTLE_CYCLES=1 → 400 mismatches; err_count saturates at 255, fail_mask=1111, done at 400 cycles.
